// File: rtl/rvv_alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : rvv_alu_sequencer_if
// Brief    : Request, ALU-wrapper and writeback bundle of the vector issue controller.
// Revision : 1.0 - initial release
// ============================================================================
interface rvv_alu_sequencer_if #(
    parameter int unsigned VLEN     = 17'd128,
    parameter int unsigned NB_LANES = 1
);
    localparam int unsigned c_L = 1 << NB_LANES;

    logic                req_valid;
    logic                req_ready;
    logic [5:0]          req_opcode;
    logic                req_mask;
    logic [2:0]          req_vsew;
    logic [2:0]          req_op_type;
    logic [16:0]         req_vl;
    logic [VLEN-1:0]     req_vs1;
    logic [VLEN-1:0]     req_vs2;
    logic [VLEN-1:0]     req_vd_old;

    logic                alu_run;
    logic [5:0]          alu_opcode;
    logic                alu_mask;
    logic [2:0]          alu_vsew;
    logic [2:0]          alu_op_type;
    logic [16:0]         alu_vl;
    logic [VLEN-1:0]     alu_vs1;
    logic [VLEN-1:0]     alu_vs2;
    logic [16:0]         alu_arith_remaining;
    logic [64*c_L-1:0]   alu_vd;
    logic [17*c_L-1:0]   alu_regi;
    logic [c_L-1:0]      alu_res;
    logic                alu_done;
    logic                alu_instr_valid;

    logic                wb_valid;
    logic                wb_ready;
    logic [VLEN-1:0]     wb_vd;
    logic                wb_illegal;

    // master: the sequencer itself; slave: decode, ALU wrapper and writeback around it
    modport master (
        input  req_valid, req_opcode, req_mask, req_vsew, req_op_type, req_vl,
               req_vs1, req_vs2, req_vd_old,
               alu_vd, alu_regi, alu_res, alu_done, alu_instr_valid, wb_ready,
        output req_ready, alu_run, alu_opcode, alu_mask, alu_vsew, alu_op_type, alu_vl,
               alu_vs1, alu_vs2, alu_arith_remaining, wb_valid, wb_vd, wb_illegal
    );

    modport slave (
        output req_valid, req_opcode, req_mask, req_vsew, req_op_type, req_vl,
               req_vs1, req_vs2, req_vd_old,
               alu_vd, alu_regi, alu_res, alu_done, alu_instr_valid, wb_ready,
        input  req_ready, alu_run, alu_opcode, alu_mask, alu_vsew, alu_op_type, alu_vl,
               alu_vs1, alu_vs2, alu_arith_remaining, wb_valid, wb_vd, wb_illegal
    );
endinterface
`default_nettype wire

// File: rtl/rvv_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rvv_alu_sequencer
// Brief    : Issues one vector ALU instruction, merges lane chunks, hands result to writeback.
// Revision : 1.0 - initial release
// ============================================================================
module rvv_alu_sequencer #(
    parameter int unsigned VLEN       = 17'd128,
    parameter int unsigned LANE_WIDTH = 3'b011,
    parameter int unsigned NB_LANES   = 1
) (
    input wire clk,
    input wire resetn,
    rvv_alu_sequencer_if.master bus
);
    localparam int unsigned c_L      = 1 << NB_LANES;
    localparam int unsigned c_LW     = 1 << LANE_WIDTH;
    localparam int unsigned c_NCHUNK = VLEN >> LANE_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_req_ready;
    logic            w_wb_valid;

    logic            r_run;
    logic [5:0]      r_opcode;
    logic            r_mask;
    logic [2:0]      r_vsew;
    logic [2:0]      r_op_type;
    logic [16:0]     r_vl;
    logic [VLEN-1:0] r_vs1;
    logic [VLEN-1:0] r_vs2;
    logic [16:0]     r_rem;
    logic [VLEN-1:0] r_dest;
    logic [10:0]     r_sub_cnt;
    logic            r_first;
    logic            r_wb_illegal;

    logic [31:0]     w_req_shamt;
    logic [31:0]     w_req_ne;
    logic [16:0]     w_req_n;
    logic [31:0]     w_cfg_shamt;
    logic [31:0]     w_sub_last;
    logic            w_wrap;
    logic [16:0]     w_step;
    logic [VLEN-1:0] w_merged;
    logic            w_rejected;
    logic            w_unused_vd;

    // Element count for the incoming request: masked ops cover the whole register.
    always_comb begin
        w_req_shamt = 32'(bus.req_vsew) + 32'd3;
        w_req_ne    = VLEN >> w_req_shamt;
        if (bus.req_mask) begin
            w_req_n = w_req_ne[16:0];
        end else if (32'(bus.req_vl) < w_req_ne) begin
            w_req_n = bus.req_vl;
        end else begin
            w_req_n = w_req_ne[16:0];
        end
    end

    // Elements wider than a lane chunk take several RUN cycles per lane-group step.
    always_comb begin
        w_cfg_shamt = 32'(r_vsew) + 32'd3;
        if (w_cfg_shamt <= LANE_WIDTH) begin
            w_sub_last = 32'd0;
        end else begin
            w_sub_last = (32'd1 << (w_cfg_shamt - LANE_WIDTH)) - 32'd1;
        end
        w_wrap = ({21'd0, r_sub_cnt} == w_sub_last);
        w_step = (r_rem < 17'(c_L)) ? r_rem : 17'(c_L);
    end

    // Chunk merge: lanes scanned upward so the highest lane wins a shared index;
    // indices past the last chunk match nothing and are dropped.
    always_comb begin
        w_merged = r_dest;
        for (int c = 0; c < int'(c_NCHUNK); c++) begin
            for (int l = 0; l < int'(c_L); l++) begin
                if (bus.alu_res[l] && (bus.alu_regi[17*l +: 17] == 17'(c))) begin
                    w_merged[c*c_LW +: c_LW] = bus.alu_vd[64*l +: c_LW];
                end
            end
        end
    end

    assign w_rejected  = r_first && !bus.alu_instr_valid;
    assign w_unused_vd = ^bus.alu_vd;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_wb_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_state_next = (w_req_n == 17'd0) ? S_WB : S_RUN;
                end
            end
            S_RUN: begin
                if (w_rejected || bus.alu_done) begin
                    w_state_next = S_WB;
                end
            end
            S_WB: begin
                w_wb_valid = 1'b1;
                if (bus.wb_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_run        <= 1'b0;
            r_opcode     <= '0;
            r_mask       <= 1'b0;
            r_vsew       <= '0;
            r_op_type    <= '0;
            r_vl         <= '0;
            r_vs1        <= '0;
            r_vs2        <= '0;
            r_rem        <= '0;
            r_dest       <= '0;
            r_sub_cnt    <= '0;
            r_first      <= 1'b0;
            r_wb_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_opcode     <= bus.req_opcode;
                        r_mask       <= bus.req_mask;
                        r_vsew       <= bus.req_vsew;
                        r_op_type    <= bus.req_op_type;
                        r_vl         <= bus.req_vl;
                        r_vs1        <= bus.req_vs1;
                        r_vs2        <= bus.req_vs2;
                        r_dest       <= bus.req_vd_old;
                        r_rem        <= w_req_n;
                        r_sub_cnt    <= '0;
                        r_first      <= 1'b1;
                        r_wb_illegal <= 1'b0;
                        r_run        <= (w_req_n != 17'd0);
                    end
                end
                S_RUN: begin
                    r_first <= 1'b0;
                    if (w_rejected) begin
                        r_run        <= 1'b0;
                        r_wb_illegal <= 1'b1;
                    end else begin
                        r_dest <= w_merged;
                        if (w_wrap) begin
                            r_sub_cnt <= '0;
                            r_rem     <= r_rem - w_step;
                        end else begin
                            r_sub_cnt <= r_sub_cnt + 11'd1;
                        end
                        if (bus.alu_done) begin
                            r_run <= 1'b0;
                        end
                    end
                end
                S_WB: begin
                    if (bus.wb_ready) begin
                        r_wb_illegal <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready           = w_req_ready;
    assign bus.alu_run             = r_run;
    assign bus.alu_opcode          = r_opcode;
    assign bus.alu_mask            = r_mask;
    assign bus.alu_vsew            = r_vsew;
    assign bus.alu_op_type         = r_op_type;
    assign bus.alu_vl              = r_vl;
    assign bus.alu_vs1             = r_vs1;
    assign bus.alu_vs2             = r_vs2;
    assign bus.alu_arith_remaining = r_rem;
    assign bus.wb_valid            = w_wb_valid;
    assign bus.wb_vd               = r_dest;
    assign bus.wb_illegal          = r_wb_illegal;
endmodule
`default_nettype wire
